// File: rtl/sfp_ctrl.sv
// Output-side special-function sequencer: accumulates psum rows over several
// passes in a row buffer, then drains them with per-lane ReLU.
module sfp_ctrl #(
  parameter int DATA_W = 16,
  parameter int COL    = 8,
  parameter int DEPTH  = 16,
  parameter int AW     = $clog2(DEPTH) + 1,
  parameter int PW     = 4
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  start_i,
  input  logic [AW-1:0]         num_rows_i,
  input  logic [PW-1:0]         num_pass_i,
  input  logic                  in_valid_i,
  output logic                  in_ready_o,
  input  logic [DATA_W*COL-1:0] in_data_i,
  output logic                  out_valid_o,
  input  logic                  out_ready_i,
  output logic [DATA_W*COL-1:0] out_data_o,
  output logic                  busy_o,
  output logic                  done_o
);

  localparam int ROW_W = DATA_W * COL;
  localparam int RW    = $clog2(DEPTH);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ACC   = 2'd1,
    DRAIN = 2'd2,
    DONE  = 2'd3
  } state_t;

  state_t            state_q, state_d;
  logic [RW-1:0]     r_q, r_d;
  logic [PW-1:0]     p_q, p_d;
  logic [AW-1:0]     rows_q, rows_d;
  logic [PW-1:0]     npass_q, npass_d;
  logic              out_valid_q, out_valid_d;
  logic [ROW_W-1:0]  out_data_q, out_data_d;

  logic [ROW_W-1:0]  rowbuf_q [DEPTH];

  logic [AW-1:0]     rows_clamp;
  logic [RW-1:0]     r_nxt;
  logic              last_row;
  logic              last_pass;
  logic              acc_hs;

  // Lane-wise modulo-2^DATA_W add; overflow wraps by design.
  function automatic logic [ROW_W-1:0] add_row(input logic [ROW_W-1:0] a,
                                               input logic [ROW_W-1:0] b);
    logic signed [DATA_W-1:0] la, lb, ls;
    logic [ROW_W-1:0]         res;
    res = '0;
    for (int i = 0; i < COL; i++) begin
      la = a[i*DATA_W +: DATA_W];
      lb = b[i*DATA_W +: DATA_W];
      ls = la + lb;
      res[i*DATA_W +: DATA_W] = ls;
    end
    return res;
  endfunction

  function automatic logic [ROW_W-1:0] relu_row(input logic [ROW_W-1:0] a);
    logic signed [DATA_W-1:0] lane;
    logic [ROW_W-1:0]         res;
    res = '0;
    for (int i = 0; i < COL; i++) begin
      lane = a[i*DATA_W +: DATA_W];
      res[i*DATA_W +: DATA_W] = (lane < 0) ? '0 : lane;
    end
    return res;
  endfunction

  assign rows_clamp = (num_rows_i > AW'(DEPTH)) ? AW'(DEPTH) : num_rows_i;
  assign r_nxt      = r_q + RW'(1);
  assign last_row   = (AW'(r_q) == (rows_q - AW'(1)));
  assign last_pass  = (p_q == (npass_q - PW'(1)));
  assign acc_hs     = (state_q == ACC) && in_valid_i;

  always_comb begin
    state_d     = state_q;
    r_d         = r_q;
    p_d         = p_q;
    rows_d      = rows_q;
    npass_d     = npass_q;
    out_valid_d = out_valid_q;
    out_data_d  = out_data_q;
    case (state_q)
      IDLE: begin
        if (start_i) begin
          rows_d  = rows_clamp;
          npass_d = num_pass_i;
          r_d     = '0;
          p_d     = '0;
          state_d = ((rows_clamp == '0) || (num_pass_i == '0)) ? DONE : ACC;
        end
      end
      ACC: begin
        if (in_valid_i) begin
          if (last_row) begin
            r_d = '0;
            p_d = p_q + PW'(1);
            if (last_pass) state_d = DRAIN;
          end else begin
            r_d = r_nxt;
          end
        end
      end
      DRAIN: begin
        // First DRAIN cycle loads row 0; afterwards each accept prefetches the next row.
        if (!out_valid_q) begin
          out_valid_d = 1'b1;
          out_data_d  = relu_row(rowbuf_q[r_q]);
        end else if (out_ready_i) begin
          if (last_row) begin
            out_valid_d = 1'b0;
            state_d     = DONE;
          end else begin
            r_d        = r_nxt;
            out_data_d = relu_row(rowbuf_q[r_nxt]);
          end
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= IDLE;
      r_q         <= '0;
      p_q         <= '0;
      rows_q      <= '0;
      npass_q     <= '0;
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
    end else begin
      state_q     <= state_d;
      r_q         <= r_d;
      p_q         <= p_d;
      rows_q      <= rows_d;
      npass_q     <= npass_d;
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
    end
  end

  // Row buffer is not reset: pass 0 overwrites every row in use.
  always_ff @(posedge clk) begin
    if (acc_hs) begin
      rowbuf_q[r_q] <= (p_q == '0) ? in_data_i : add_row(rowbuf_q[r_q], in_data_i);
    end
  end

  assign in_ready_o  = (state_q == ACC);
  assign out_valid_o = out_valid_q;
  assign out_data_o  = out_data_q;
  assign busy_o      = (state_q != IDLE);
  assign done_o      = (state_q == DONE);

endmodule

// File: tb/tb_sfp_ctrl.sv
// Directed bench for sfp_ctrl: accumulation, ReLU, wrap, backpressure,
// mid-tile reset and size corner cases.
module tb_sfp_ctrl;

  localparam int ROW_W = 128;

  logic             clk = 1'b0;
  logic             reset = 1'b1;
  logic             start = 1'b0;
  logic [4:0]       num_rows = '0;
  logic [3:0]       num_pass = '0;
  logic             in_valid = 1'b0;
  logic             in_ready;
  logic [ROW_W-1:0] in_data = '0;
  logic             out_valid;
  logic             out_ready = 1'b0;
  logic [ROW_W-1:0] out_data;
  logic             busy;
  logic             done;

  int checks = 0;
  int errors = 0;
  int in_hs = 0;
  int done_cnt = 0;
  int rdy_cyc = 0;

  sfp_ctrl dut (
    .clk        (clk),
    .reset      (reset),
    .start_i    (start),
    .num_rows_i (num_rows),
    .num_pass_i (num_pass),
    .in_valid_i (in_valid),
    .in_ready_o (in_ready),
    .in_data_i  (in_data),
    .out_valid_o(out_valid),
    .out_ready_i(out_ready),
    .out_data_o (out_data),
    .busy_o     (busy),
    .done_o     (done)
  );

  always #5 clk = ~clk;

  // Mid-cycle counters of handshakes and pulses.
  always @(negedge clk) begin
    if (in_valid && in_ready) in_hs <= in_hs + 1;
    if (done) done_cnt <= done_cnt + 1;
    if (in_ready) rdy_cyc <= rdy_cyc + 1;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: observed timeout required completion");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [ROW_W-1:0] obs,
                       input logic [ROW_W-1:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [ROW_W-1:0] mkrow(input logic [15:0] l0, input logic [15:0] rest);
    logic [ROW_W-1:0] r;
    for (int i = 0; i < 8; i++) r[i*16 +: 16] = rest;
    r[15:0] = l0;
    return r;
  endfunction

  function automatic logic [ROW_W-1:0] row2(input logic [15:0] l0, input logic [15:0] l1);
    logic [ROW_W-1:0] r;
    r = '0;
    r[15:0]  = l0;
    r[31:16] = l1;
    return r;
  endfunction

  task automatic do_start(input logic [4:0] nr, input logic [3:0] np);
    num_rows = nr;
    num_pass = np;
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  task automatic send_row(input logic [ROW_W-1:0] d, input int gap);
    int n;
    in_valid = 1'b0;
    repeat (gap) tick();
    in_valid = 1'b1;
    in_data  = d;
    n = 0;
    while (!in_ready && n < 50) begin
      tick();
      n++;
    end
    check("send_ready", in_ready, 1);
    tick();
    in_valid = 1'b0;
  endtask

  task automatic recv_row(input string tag, input logic [ROW_W-1:0] exp);
    int n;
    out_ready = 1'b1;
    n = 0;
    while (!out_valid && n < 50) begin
      tick();
      n++;
    end
    check({tag, "_valid"}, out_valid, 1);
    check(tag, out_data, exp);
    tick();
  endtask

  initial begin
    int hs0, dc0, rc0;

    // Reset state
    repeat (2) tick();
    check("rst_in_ready", in_ready, 0);
    check("rst_out_valid", out_valid, 0);
    check("rst_out_data", out_data, '0);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    reset = 1'b0;
    tick();

    // Test 1: rows=2, passes=1, ReLU on lane0 of row1
    dc0 = done_cnt;
    do_start(5'd2, 4'd1);
    check("t1_busy", busy, 1);
    check("t1_in_ready", in_ready, 1);
    send_row(mkrow(16'd5, 16'd5), 0);
    send_row(mkrow(16'hFFFD, 16'd7), 0);
    check("t1_ov_lat0", out_valid, 0);
    out_ready = 1'b1;
    tick();
    check("t1_ov_lat1", out_valid, 1);
    check("t1_row0", out_data, mkrow(16'd5, 16'd5));
    tick();
    check("t1_ov_row1", out_valid, 1);
    check("t1_row1", out_data, mkrow(16'd0, 16'd7));
    tick();
    check("t1_ov_end", out_valid, 0);
    check("t1_done", done, 1);
    tick();
    check("t1_done_off", done, 0);
    check("t1_busy_off", busy, 0);
    check("t1_done_cnt", done_cnt - dc0, 1);
    out_ready = 1'b0;

    // Test 2: rows=1, passes=3
    hs0 = in_hs;
    do_start(5'd1, 4'd3);
    send_row(row2(16'd10, 16'd10), 0);
    send_row(row2(16'hFFFC, 16'd4), 1);
    send_row(row2(16'hFFF8, 16'd1), 0);
    check("t2_hs", in_hs - hs0, 3);
    recv_row("t2_row0", row2(16'd0, 16'd15));
    check("t2_done", done, 1);
    tick();

    // Test 3: wrap past 0x7FFF
    do_start(5'd1, 4'd2);
    send_row(mkrow(16'h7FFF, 16'h0100), 0);
    send_row(mkrow(16'h0001, 16'h0100), 0);
    recv_row("t3_row0", mkrow(16'h0000, 16'h0200));
    check("t3_done", done, 1);
    tick();

    // Test 4: backpressure, rows=4, passes=2, input gaps
    out_ready = 1'b0;
    do_start(5'd4, 4'd2);
    for (int i = 0; i < 4; i++) send_row(mkrow(16'(100 * (i + 1)), 16'(100 * (i + 1))), $urandom_range(0, 2));
    send_row(mkrow(16'd1, 16'd1), $urandom_range(0, 2));
    send_row(mkrow(16'd2, 16'd2), $urandom_range(0, 2));
    send_row(mkrow(16'd3, 16'd3), $urandom_range(0, 2));
    send_row(mkrow(16'hFE0C, 16'd4), $urandom_range(0, 2));
    recv_row("t4_row0", mkrow(16'd101, 16'd101));
    check("t4_row1", out_data, mkrow(16'd202, 16'd202));
    out_ready = 1'b0;
    for (int i = 0; i < 5; i++) begin
      tick();
      check("t4_stall_valid", out_valid, 1);
      check("t4_stall_data", out_data, mkrow(16'd202, 16'd202));
    end
    out_ready = 1'b1;
    tick();
    check("t4_nobubble2", out_valid, 1);
    check("t4_row2", out_data, mkrow(16'd303, 16'd303));
    tick();
    check("t4_nobubble3", out_valid, 1);
    check("t4_row3", out_data, mkrow(16'd0, 16'd404));
    tick();
    check("t4_done", done, 1);
    check("t4_ov_end", out_valid, 0);
    tick();
    out_ready = 1'b0;

    // Test 5: reset during pass 1, then a clean tile
    do_start(5'd3, 4'd2);
    send_row(mkrow(16'd9, 16'd9), 0);
    send_row(mkrow(16'd9, 16'd9), 0);
    send_row(mkrow(16'd9, 16'd9), 0);
    send_row(mkrow(16'd9, 16'd9), 0);
    reset = 1'b1;
    #1;
    check("t5_busy", busy, 0);
    check("t5_in_ready", in_ready, 0);
    check("t5_out_valid", out_valid, 0);
    check("t5_out_data", out_data, '0);
    check("t5_done", done, 0);
    tick();
    reset = 1'b0;
    tick();
    do_start(5'd3, 4'd1);
    send_row(mkrow(16'd1, 16'd1), 0);
    send_row(mkrow(16'd2, 16'd2), 0);
    send_row(mkrow(16'd3, 16'd3), 0);
    recv_row("t5_row0", mkrow(16'd1, 16'd1));
    recv_row("t5_row1", mkrow(16'd2, 16'd2));
    recv_row("t5_row2", mkrow(16'd3, 16'd3));
    check("t5_done_end", done, 1);
    tick();
    out_ready = 1'b0;

    // Test 6: zero-size tile
    rc0 = rdy_cyc;
    do_start(5'd0, 4'd2);
    check("t6_done", done, 1);
    check("t6_busy", busy, 1);
    check("t6_in_ready", in_ready, 0);
    tick();
    check("t6_done_off", done, 0);
    check("t6_idle", busy, 0);
    check("t6_rdy_cyc", rdy_cyc - rc0, 0);

    // Test 7: num_rows=20 clamps to 16; start during DRAIN is ignored
    hs0 = in_hs;
    dc0 = done_cnt;
    do_start(5'd20, 4'd1);
    for (int i = 0; i < 16; i++) send_row(mkrow(16'(i + 1), 16'(i + 1)), 0);
    check("t7_hs", in_hs - hs0, 16);
    check("t7_in_ready_off", in_ready, 0);
    for (int i = 0; i < 16; i++) begin
      if (i == 5) start = 1'b1;
      recv_row("t7_row", mkrow(16'(i + 1), 16'(i + 1)));
      start = 1'b0;
    end
    check("t7_done", done, 1);
    tick();
    check("t7_idle", busy, 0);
    check("t7_no_acc", in_ready, 0);
    tick();
    check("t7_done_cnt", done_cnt - dc0, 1);
    out_ready = 1'b0;

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
